// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit controller: FSM state encoding
// and the line multiplexer select codes.
package uart_tx_ctrl_pkg;

    // Frame sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Line mux select codes: start bit (0), stop/idle (1), serial data, parity
    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_ctrl_parity.sv
// Parity generator for the UART transmitter. Operates on the latched frame
// data and parity type, so its output is stable for the whole frame.
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Even parity is the XOR of all data bits; odd parity is its inverse
    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller. Sequences START, DATA, optional PARITY and
// STOP, drives the line mux select and serializer enable, and aborts a frame
// through a watchdog when the serializer never reports completion.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WDOG_CYC   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  Ser_Done,
    output logic                  Ser_En,
    output logic [1:0]            Mux_Sel,
    output logic                  Par_Bit,
    output logic                  busy,
    output logic                  Frame_Err
);

    localparam int WDOG_W = $clog2(WDOG_CYC + 1);

    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYC);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    tx_state_t             state_reg;
    tx_state_t             state_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic [WDOG_W-1:0]     wdog_reg;
    logic                  frame_err_reg;
    logic                  frame_err_next;
    logic                  wdog_expire;

    // The current DATA cycle is the last one the watchdog allows
    assign wdog_expire = (wdog_reg == WDOG_LAST);

    // State register and registered abort pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Capture the byte and its parity configuration when a frame is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && Data_Valid) begin
            data_reg    <= P_Data;
            par_en_reg  <= PAR_EN;
            par_typ_reg <= PAR_TYP;
        end
    end

    // Watchdog: cleared while entering DATA, counts DATA cycles, saturates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_reg <= '0;
        end else if (state_reg == ST_START) begin
            wdog_reg <= '0;
        end else if (state_reg == ST_DATA && wdog_reg != WDOG_MAX) begin
            wdog_reg <= wdog_reg + WDOG_W'(1);
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_next     = state_reg;
        frame_err_next = 1'b0;
        Mux_Sel        = MUX_STOP;
        Ser_En         = 1'b0;
        busy           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Data_Valid) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                Mux_Sel    = MUX_START;
                Ser_En     = 1'b1;
                busy       = 1'b1;
                state_next = ST_DATA;
            end
            ST_DATA: begin
                Mux_Sel = MUX_DATA;
                Ser_En  = 1'b1;
                busy    = 1'b1;
                // Completion takes priority over a simultaneous watchdog expiry
                if (Ser_Done) begin
                    state_next = par_en_reg ? ST_PARITY : ST_STOP;
                end else if (wdog_expire) begin
                    state_next     = ST_IDLE;
                    frame_err_next = 1'b1;
                end
            end
            ST_PARITY: begin
                Mux_Sel    = MUX_PAR;
                busy       = 1'b1;
                state_next = ST_STOP;
            end
            ST_STOP: begin
                Mux_Sel    = MUX_STOP;
                busy       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign Frame_Err = frame_err_reg;

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (data_reg),
        .par_typ (par_typ_reg),
        .par_bit (Par_Bit)
    );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: the stimulus process pushes the expected
// per-cycle output tuple, and a monitor pops and compares one tuple per cycle.
module tb_uart_tx_ctrl;
    import uart_tx_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0] mux;
        logic       se;
        logic       bz;
        logic       par;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Data_Valid = 1'b0;
    logic [7:0] P_Data = 8'h00;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       Ser_Done = 1'b0;
    logic       Ser_En;
    logic [1:0] Mux_Sel;
    logic       Par_Bit;
    logic       busy;
    logic       Frame_Err;

    exp_t exp_q[$];
    logic mon_en = 1'b0;
    logic cur_par = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8), .WDOG_CYC(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .Data_Valid (Data_Valid),
        .P_Data     (P_Data),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Ser_Done   (Ser_Done),
        .Ser_En     (Ser_En),
        .Mux_Sel    (Mux_Sel),
        .Par_Bit    (Par_Bit),
        .busy       (busy),
        .Frame_Err  (Frame_Err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] m, input logic se, input logic bz,
                                input logic p, input logic fe);
        exp_t e;
        e.mux = m;
        e.se  = se;
        e.bz  = bz;
        e.par = p;
        e.fe  = fe;
        return e;
    endfunction

    // Monitor: one expected tuple per cycle, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        exp_t obs;
        if (mon_en) begin
            obs = mk(Mux_Sel, Ser_En, busy, Par_Bit, Frame_Err);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty cyc%0d: got mux=%b ser_en=%b busy=%b par=%b ferr=%b, required no output pending",
                         cyc, obs.mux, obs.se, obs.bz, obs.par, obs.fe);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL sb_cycle cyc%0d: got mux=%b ser_en=%b busy=%b par=%b ferr=%b, required mux=%b ser_en=%b busy=%b par=%b ferr=%b",
                             cyc, obs.mux, obs.se, obs.bz, obs.par, obs.fe,
                             e.mux, e.se, e.bz, e.par, e.fe);
                end
            end
            cyc++;
        end
    end

    // Push the expectation for the current cycle and advance one clock
    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One frame from an IDLE cycle back to an IDLE cycle. ndata is the DATA
    // cycle where Ser_Done is raised (or the watchdog length when done=0).
    // noisy keeps Data_Valid high and scrambles inputs during the frame.
    task automatic run_frame(input logic [7:0] data, input logic en, input logic typ,
                             input int ndata, input logic done, input logic exp_par,
                             input logic noisy);
        P_Data     = data;
        PAR_EN     = en;
        PAR_TYP    = typ;
        Data_Valid = 1'b1;
        step(mk(MUX_STOP, 1'b0, 1'b0, cur_par, 1'b0));
        cur_par = exp_par;
        if (noisy) begin
            P_Data   = ~data;
            PAR_TYP  = ~typ;
            PAR_EN   = ~en;
            Ser_Done = 1'b1;
        end else begin
            Data_Valid = 1'b0;
        end
        step(mk(MUX_START, 1'b1, 1'b1, cur_par, 1'b0));
        for (int k = 1; k <= ndata; k++) begin
            if (noisy) begin
                P_Data  = P_Data ^ 8'h5A;
                PAR_TYP = ~PAR_TYP;
                PAR_EN  = ~PAR_EN;
            end
            Ser_Done = done && (k == ndata);
            step(mk(MUX_DATA, 1'b1, 1'b1, cur_par, 1'b0));
        end
        Ser_Done = noisy;
        if (done) begin
            if (en) step(mk(MUX_PAR, 1'b0, 1'b1, cur_par, 1'b0));
            step(mk(MUX_STOP, 1'b0, 1'b1, cur_par, 1'b0));
        end else begin
            step(mk(MUX_STOP, 1'b0, 1'b0, cur_par, 1'b1));
        end
        Ser_Done = 1'b0;
    endtask

    // Start a frame and pull reset low during the third DATA cycle
    task automatic reset_mid(input logic [7:0] data, input logic en, input logic typ,
                             input logic exp_par);
        P_Data     = data;
        PAR_EN     = en;
        PAR_TYP    = typ;
        Data_Valid = 1'b1;
        step(mk(MUX_STOP, 1'b0, 1'b0, cur_par, 1'b0));
        cur_par    = exp_par;
        Data_Valid = 1'b0;
        step(mk(MUX_START, 1'b1, 1'b1, cur_par, 1'b0));
        step(mk(MUX_DATA, 1'b1, 1'b1, cur_par, 1'b0));
        step(mk(MUX_DATA, 1'b1, 1'b1, cur_par, 1'b0));
        rst     = 1'b0;
        cur_par = 1'b0;
        step(mk(MUX_STOP, 1'b0, 1'b0, 1'b0, 1'b0));
        step(mk(MUX_STOP, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        // Reset state, with Data_Valid offered while reset is held
        Data_Valid = 1'b1;
        step(mk(MUX_STOP, 1'b0, 1'b0, 1'b0, 1'b0));
        step(mk(MUX_STOP, 1'b0, 1'b0, 1'b0, 1'b0));
        rst        = 1'b1;
        Data_Valid = 1'b0;
        step(mk(MUX_STOP, 1'b0, 1'b0, 1'b0, 1'b0));

        //        data   en    typ   nd  done  par   noisy
        run_frame(8'hA5, 1'b1, 1'b0, 8,  1'b1, 1'b0, 1'b0);
        run_frame(8'h01, 1'b1, 1'b1, 8,  1'b1, 1'b0, 1'b0);
        run_frame(8'h01, 1'b1, 1'b0, 8,  1'b1, 1'b1, 1'b0);
        run_frame(8'hFF, 1'b0, 1'b0, 8,  1'b1, 1'b0, 1'b0);
        run_frame(8'h3C, 1'b1, 1'b1, 3,  1'b1, 1'b1, 1'b1);
        run_frame(8'h80, 1'b1, 1'b0, 5,  1'b1, 1'b1, 1'b0);
        run_frame(8'h12, 1'b1, 1'b0, 15, 1'b0, 1'b0, 1'b0);
        run_frame(8'h07, 1'b1, 1'b0, 15, 1'b1, 1'b1, 1'b0);
        run_frame(8'hC3, 1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0);
        reset_mid(8'h0F, 1'b1, 1'b1, 1'b1);
        run_frame(8'h5A, 1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b0);

        step(mk(MUX_STOP, 1'b0, 1'b0, cur_par, 1'b0));
        step(mk(MUX_STOP, 1'b0, 1'b0, cur_par, 1'b0));
        mon_en = 1'b0;
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL provide parameter: DATA_WIDTH, 8, width of P_Data and serializer frame.
REQ-002 SHALL provide parameter: WDOG_CYC, 15, max DATA-state cycles without Ser_Done before abort.
REQ-003 SHALL provide port: clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL provide port: rst  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port: Data_Valid  input  1  new byte offered on P_Data.
REQ-006 SHALL provide port: P_Data  input  DATA_WIDTH  byte to transmit, sampled for parity.
REQ-007 SHALL provide port: PAR_EN  input  1  1 = parity bit inserted.
REQ-008 SHALL provide port: PAR_TYP  input  1  0 = even, 1 = odd.
REQ-009 SHALL provide port: Ser_Done  input  1  serializer finished shifting DATA_WIDTH bits.
REQ-010 SHALL provide port: Ser_En  output  1  enables serializer shifting.
REQ-011 SHALL provide port: Mux_Sel  output  2  line mux select: 00 start(0), 01 stop/idle(1), 10 Ser_Data, 11 Par_Bit.
REQ-012 SHALL provide port: Par_Bit  output  1  computed parity bit.
REQ-013 SHALL provide port: busy  output  1  frame in progress; also drives serializer busy input.
REQ-014 SHALL provide port: Frame_Err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP in one state register; outputs Moore-decoded from state only (except Frame_Err, registered).
REQ-016 IDLE: Mux_Sel=01, Ser_En=0, busy=0; Data_Valid=1 -> START next edge.
REQ-017 On IDLE acceptance edge SHALL latch P_Data, PAR_EN, PAR_TYP; later input changes have no effect until next frame.
REQ-018 START: exactly 1 cycle, Mux_Sel=00, Ser_En=1, busy=1; -> DATA.
REQ-019 DATA: Mux_Sel=10, Ser_En=1, busy=1; Ser_Done=1 -> PARITY if latched PAR_EN=1 else STOP.
REQ-020 PARITY: exactly 1 cycle, Mux_Sel=11, Ser_En=0, busy=1; -> STOP.
REQ-021 STOP: exactly 1 cycle, Mux_Sel=01, Ser_En=0, busy=1; -> IDLE unconditionally (minimum one IDLE cycle between frames).
REQ-022 Par_Bit SHALL equal XOR of latched data when PAR_TYP=0, its inverse when PAR_TYP=1; stable from START through STOP.
REQ-023 Data_Valid while busy=1 SHALL be ignored; no queuing.
REQ-024 Ser_Done outside DATA SHALL be ignored.
REQ-025 Watchdog counter (width ceil(log2(WDOG_CYC+1))) SHALL clear on DATA entry, count each DATA cycle, saturate; reaching WDOG_CYC without Ser_Done -> IDLE and Frame_Err=1 for one cycle.
REQ-026 Ser_Done and watchdog expiry in same cycle: Ser_Done wins, no Frame_Err.
REQ-027 Frame length SHALL be 1 + DATA-cycles + PAR_EN + 1 cycles, IDLE-to-IDLE excluded.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, Mux_Sel=01, Ser_En=0, busy=0, Frame_Err=0, Par_Bit=0, latched data/config=0, watchdog=0.
REQ-029 Reset mid-frame SHALL abort frame; line returns to 1 immediately; no resume after release.
REQ-030 First acceptance possible on first clk edge after rst deassertion.

Structure
REQ-031 Shared package SHALL hold state encoding (3-bit) and Mux_Sel codes (MUX_START, MUX_STOP, MUX_DATA, MUX_PAR).
REQ-032 Parity SHALL be a sub-module uart_parity_calc (latched data, PAR_TYP -> Par_Bit), purely combinational on registered inputs.

Verification
REQ-033 P_Data=0xA5, PAR_EN=1, PAR_TYP=0, Ser_Done after 8 DATA cycles -> Mux_Sel 00,10x8,11,01 then IDLE; Par_Bit=0.
REQ-034 P_Data=0x01, PAR_EN=1, PAR_TYP=1 -> Par_Bit=0; same with PAR_TYP=0 -> Par_Bit=1.
REQ-035 PAR_EN=0, P_Data=0xFF -> PARITY skipped, DATA->STOP, frame 10 cycles.
REQ-036 Data_Valid held high and P_Data/PAR_TYP toggled during frame -> no restart, Par_Bit from latched values, next frame starts after one IDLE cycle.
REQ-037 Ser_Done never asserted, WDOG_CYC=15 -> after 15 DATA cycles IDLE, Frame_Err single pulse, busy=0.
REQ-038 rst low in DATA cycle 3 -> immediately Mux_Sel=01, busy=0, Ser_En=0; after release Data_Valid starts clean frame.
